// File: rtl/dcache_pkg.sv
// Shared definitions for the data-cache line flush/fill controller.
package dcache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WB_RD,
        WB_WR,
        FILL_REQ,
        FILL_WAIT,
        DONE
    } flush_state_e;

    // Byte offset bits within a data word.
    localparam int unsigned WORD_SHIFT = 2;

endpackage

// File: rtl/dcache_flush_ctrl_if.sv
// Memory-side request/response bus between the flush controller (master) and memory (slave).
interface dcache_flush_ctrl_if #(
    parameter int unsigned ADDRBITS = 32,
    parameter int unsigned DATABITS = 32
);
    logic [ADDRBITS-1:0] mem_addr;
    logic                mem_wrreq;
    logic                mem_rdreq;
    logic [DATABITS-1:0] mem_out;
    logic                mem_busy;
    logic [DATABITS-1:0] mem_in;
    logic                mem_in_valid;

    modport master (
        output mem_addr, mem_wrreq, mem_rdreq, mem_out,
        input  mem_busy, mem_in, mem_in_valid
    );

    modport slave (
        input  mem_addr, mem_wrreq, mem_rdreq, mem_out,
        output mem_busy, mem_in, mem_in_valid
    );
endinterface

// File: rtl/dcache_flush_ctrl.sv
// Miss handler: writes back a dirty line word by word, then refills the line from memory.
module dcache_flush_ctrl
    import dcache_pkg::*;
#(
    parameter int unsigned DATABITS      = 32,
    parameter int unsigned ADDRBITS      = 32,
    parameter int unsigned CACHEADDRBITS = 5
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                core_req,
    input  logic [ADDRBITS-1:0] core_addr,
    input  logic                line_miss,
    input  logic                line_dirty,
    input  logic [ADDRBITS-1:0] line_memory_section,
    input  logic [DATABITS-1:0] line_data,
    output logic                flush_mode,
    output logic                flush_we,
    output logic [ADDRBITS-1:0] flush_addr,
    output logic [DATABITS-1:0] flush_in,
    output logic                busy,
    output logic                done,
    dcache_flush_ctrl_if.master mem
);

    localparam int unsigned LINE_BITS = CACHEADDRBITS + WORD_SHIFT;
    localparam logic [ADDRBITS-1:0] LINE_MASK =
        ~((ADDRBITS'(1) << LINE_BITS) - ADDRBITS'(1));
    localparam logic [CACHEADDRBITS-1:0] CNT_MAX = '1;

    flush_state_e             state_q, state_d;
    logic [CACHEADDRBITS-1:0] cnt_q, cnt_d;
    logic [ADDRBITS-1:0]      sect_q, sect_d;
    logic [ADDRBITS-1:0]      base_q, base_d;

    logic                flush_mode_q, busy_q, done_q;
    logic                mem_wrreq_q, mem_rdreq_q, fill_wait_q;
    logic [ADDRBITS-1:0] flush_addr_q, mem_addr_q;

    function automatic logic [ADDRBITS-1:0] word_addr(
        input logic [ADDRBITS-1:0]      line,
        input logic [CACHEADDRBITS-1:0] idx
    );
        return line | (ADDRBITS'(idx) << WORD_SHIFT);
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sect_d  = sect_q;
        base_d  = base_q;
        unique case (state_q)
            IDLE: begin
                if (core_req && line_miss) begin
                    state_d = line_dirty ? WB_RD : FILL_REQ;
                    base_d  = core_addr & LINE_MASK;
                    sect_d  = line_memory_section;
                    cnt_d   = '0;
                end
            end
            WB_RD: state_d = WB_WR;
            WB_WR: begin
                if (!mem.mem_busy) begin
                    if (cnt_q == CNT_MAX) begin
                        cnt_d   = '0;
                        state_d = FILL_REQ;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = WB_RD;
                    end
                end
            end
            FILL_REQ: begin
                if (!mem.mem_busy) state_d = FILL_WAIT;
            end
            FILL_WAIT: begin
                if (mem.mem_in_valid) begin
                    if (cnt_q == CNT_MAX) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = FILL_REQ;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state, so they line up with state_q.
    // flush_addr stays on the write-back word through WB_WR so line_data is held stable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            sect_q       <= '0;
            base_q       <= '0;
            flush_mode_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            mem_wrreq_q  <= 1'b0;
            mem_rdreq_q  <= 1'b0;
            fill_wait_q  <= 1'b0;
            flush_addr_q <= '0;
            mem_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sect_q       <= sect_d;
            base_q       <= base_d;
            flush_mode_q <= state_d inside {WB_RD, WB_WR, FILL_REQ, FILL_WAIT};
            busy_q       <= (state_d != IDLE);
            done_q       <= (state_d == DONE);
            mem_wrreq_q  <= (state_d == WB_WR);
            mem_rdreq_q  <= (state_d == FILL_REQ);
            fill_wait_q  <= (state_d == FILL_WAIT);
            case (state_d)
                WB_RD, WB_WR:        flush_addr_q <= word_addr(sect_d, cnt_d);
                FILL_REQ, FILL_WAIT: flush_addr_q <= word_addr(base_d, cnt_d);
                default:             flush_addr_q <= '0;
            endcase
            case (state_d)
                WB_WR:    mem_addr_q <= word_addr(sect_d, cnt_d);
                FILL_REQ: mem_addr_q <= word_addr(base_d, cnt_d);
                default:  mem_addr_q <= '0;
            endcase
        end
    end

    // Fill writes must land in the same cycle mem_in_valid arrives, so they bypass the registers.
    assign flush_we      = fill_wait_q & mem.mem_in_valid;
    assign flush_in      = flush_we ? mem.mem_in : '0;
    assign mem.mem_out   = mem_wrreq_q ? line_data : '0;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wrreq = mem_wrreq_q;
    assign mem.mem_rdreq = mem_rdreq_q;
    assign flush_mode    = flush_mode_q;
    assign flush_addr    = flush_addr_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_dcache_flush_ctrl.sv
// Randomized bench for dcache_flush_ctrl with a behavioural line/memory model.
module tb_dcache_flush_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        core_req, line_miss, line_dirty;
    logic [31:0] core_addr, line_memory_section, line_data;
    logic        flush_mode, flush_we, busy, done;
    logic [31:0] flush_addr, flush_in;

    dcache_flush_ctrl_if #(.ADDRBITS(32), .DATABITS(32)) mif ();

    dcache_flush_ctrl #(.DATABITS(32), .ADDRBITS(32), .CACHEADDRBITS(5)) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .core_req            (core_req),
        .core_addr           (core_addr),
        .line_miss           (line_miss),
        .line_dirty          (line_dirty),
        .line_memory_section (line_memory_section),
        .line_data           (line_data),
        .flush_mode          (flush_mode),
        .flush_we            (flush_we),
        .flush_addr          (flush_addr),
        .flush_in            (flush_in),
        .busy                (busy),
        .done                (done),
        .mem                 (mif)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } xact_t;

    typedef struct {
        logic [31:0] a;
        int unsigned due;
    } pend_t;

    xact_t       wr_q[$];
    xact_t       fill_q[$];
    xact_t       hold_q[$];
    logic [31:0] rd_q[$];
    pend_t       pend_q[$];
    logic [31:0] line_mem [32];
    logic        line_load;

    int unsigned cyc      = 0;
    int unsigned busy_pct = 0;
    int unsigned min_lat  = 1;
    int unsigned max_lat  = 3;
    int unsigned hold_cnt = 0;
    int unsigned done_cnt = 0;
    bit          spur_en  = 1'b0;
    bit          hold_en  = 1'b0;
    logic [31:0] hold_addr = '0;
    logic [31:0] salt      = '0;
    int          checks    = 0;
    int          failures  = 0;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ salt;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Cache line storage: synchronous read of flush_addr, write on flush_we.
    always @(posedge clk) begin
        if (line_load) begin
            for (int i = 0; i < 32; i++) line_mem[i] <= $urandom;
        end else if (flush_we) begin
            line_mem[flush_addr[6:2]] <= flush_in;
        end
        line_data <= line_mem[flush_addr[6:2]];
    end

    // Memory responder and transaction monitor.
    initial begin : env
        bit b;
        mif.mem_busy     = 1'b0;
        mif.mem_in_valid = 1'b0;
        mif.mem_in       = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset_n) pend_q.delete();
            if (hold_en && mif.mem_wrreq && mif.mem_addr == hold_addr && hold_cnt < 5) begin
                b = 1'b1;
                hold_cnt++;
                hold_q.push_back({mif.mem_addr, mif.mem_out});
            end else begin
                b = ($urandom_range(99) < busy_pct);
            end
            mif.mem_busy     = b;
            mif.mem_in_valid = 1'b0;
            mif.mem_in       = '0;
            if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                mif.mem_in_valid = 1'b1;
                mif.mem_in       = memfn(pend_q[0].a);
                void'(pend_q.pop_front());
            end else if (spur_en && (mif.mem_wrreq || !busy) && $urandom_range(1) == 1) begin
                mif.mem_in_valid = 1'b1;
                mif.mem_in       = {16'hDEAD, 16'($urandom)};
            end
            if (mif.mem_rdreq && !b) begin
                pend_q.push_back('{a: mif.mem_addr, due: cyc + $urandom_range(max_lat, min_lat)});
                rd_q.push_back(mif.mem_addr);
            end
            if (mif.mem_wrreq && !b) wr_q.push_back({mif.mem_addr, mif.mem_out});
            #1;
            if (flush_we) fill_q.push_back({flush_addr, flush_in});
            if (done) done_cnt++;
        end
    end

    task automatic check_quiet(input string tag);
        chk({tag, "_busy"},       64'(busy), 64'd0);
        chk({tag, "_done"},       64'(done), 64'd0);
        chk({tag, "_flush_mode"}, 64'(flush_mode), 64'd0);
        chk({tag, "_flush_we"},   64'(flush_we), 64'd0);
        chk({tag, "_flush_addr"}, 64'(flush_addr), 64'd0);
        chk({tag, "_flush_in"},   64'(flush_in), 64'd0);
        chk({tag, "_mem_wrreq"},  64'(mif.mem_wrreq), 64'd0);
        chk({tag, "_mem_rdreq"},  64'(mif.mem_rdreq), 64'd0);
        chk({tag, "_mem_addr"},   64'(mif.mem_addr), 64'd0);
        chk({tag, "_mem_out"},    64'(mif.mem_out), 64'd0);
    endtask

    task automatic clear_queues();
        wr_q.delete();
        rd_q.delete();
        fill_q.delete();
        done_cnt = 0;
    endtask

    // One complete miss: optional write-back of the resident line, then refill of the new line.
    task automatic run_xact(input bit dirty, input logic [31:0] sect, input logic [31:0] addr,
                            input bit hold_core);
        logic [31:0] base;
        logic [31:0] snap [32];
        bit          seen;
        base = addr & 32'hFFFF_FF80;
        for (int i = 0; i < 32; i++) snap[i] = line_mem[i];
        clear_queues();
        salt = $urandom;
        @(negedge clk); #2;
        core_req            = 1'b1;
        line_miss           = 1'b1;
        line_dirty          = dirty;
        core_addr           = addr;
        line_memory_section = sect;
        @(negedge clk); #2;
        chk("start_busy", 64'(busy), 64'd1);
        chk("start_flush_mode", 64'(flush_mode), 64'd1);
        core_addr           = $urandom;
        line_memory_section = $urandom & 32'hFFFF_FF80;
        line_dirty          = ~dirty;
        if (!hold_core) begin
            core_req  = 1'b0;
            line_miss = 1'b0;
        end
        seen = 1'b0;
        for (int n = 0; n < 4000 && !seen; n++) begin
            @(negedge clk); #2;
            seen = done;
        end
        chk("done_seen", 64'(seen), 64'd1);
        @(negedge clk); #2;
        chk("after_busy", 64'(busy), 64'd0);
        chk("after_flush_mode", 64'(flush_mode), 64'd0);
        chk("after_done", 64'(done), 64'd0);
        core_req  = 1'b0;
        line_miss = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        chk("done_pulses", 64'(done_cnt), 64'd1);
        chk("wr_count", 64'(wr_q.size()), dirty ? 64'd32 : 64'd0);
        for (int i = 0; i < 32 && i < wr_q.size(); i++)
            chk($sformatf("wr[%0d]", i), wr_q[i], {sect + 32'(4 * i), snap[i]});
        chk("rd_count", 64'(rd_q.size()), 64'd32);
        for (int i = 0; i < 32 && i < rd_q.size(); i++)
            chk($sformatf("rd[%0d]", i), 64'(rd_q[i]), 64'(base + 32'(4 * i)));
        chk("fill_count", 64'(fill_q.size()), 64'd32);
        for (int i = 0; i < 32 && i < fill_q.size(); i++)
            chk($sformatf("fill[%0d]", i), fill_q[i],
                {base + 32'(4 * i), memfn(base + 32'(4 * i))});
        for (int i = 0; i < 32; i++)
            chk($sformatf("line[%0d]", i), 64'(line_mem[i]), 64'(memfn(base + 32'(4 * i))));
    endtask

    initial begin : main
        logic [31:0] exp7;
        bit          seen;
        reset_n             = 1'b0;
        core_req            = 1'b0;
        line_miss           = 1'b0;
        line_dirty          = 1'b0;
        core_addr           = '0;
        line_memory_section = '0;
        line_load           = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset");
        @(negedge clk);
        line_load = 1'b0;
        reset_n   = 1'b1;

        // Request without a miss must leave the controller idle.
        clear_queues();
        @(negedge clk); #2;
        core_req   = 1'b1;
        line_miss  = 1'b0;
        line_dirty = 1'b1;
        core_addr  = $urandom;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk); #2;
            chk("nomiss_busy", 64'(busy), 64'd0);
            chk("nomiss_flush_mode", 64'(flush_mode), 64'd0);
        end
        chk("nomiss_wr", 64'(wr_q.size()), 64'd0);
        chk("nomiss_rd", 64'(rd_q.size()), 64'd0);
        core_req = 1'b0;

        // Clean miss with the request held through DONE.
        busy_pct = 20;
        run_xact(1'b0, 32'h0, 32'h0000_1084, 1'b1);

        // Dirty miss with spurious responses during write-back.
        spur_en = 1'b1;
        run_xact(1'b1, 32'h0000_2000, 32'h0000_3000, 1'b0);
        spur_en = 1'b0;

        // Memory stalls the write of word 7 for five cycles.
        exp7      = line_mem[7];
        hold_q.delete();
        hold_cnt  = 0;
        hold_addr = 32'h0000_401C;
        hold_en   = 1'b1;
        run_xact(1'b1, 32'h0000_4000, 32'h0000_6000, 1'b0);
        hold_en = 1'b0;
        chk("hold_samples", 64'(hold_q.size()), 64'd5);
        for (int i = 0; i < hold_q.size(); i++)
            chk($sformatf("hold[%0d]", i), hold_q[i], {hold_addr, exp7});

        for (int k = 0; k < 6; k++) begin
            busy_pct = $urandom_range(50);
            min_lat  = $urandom_range(2, 1);
            max_lat  = min_lat + $urandom_range(3);
            spur_en  = ($urandom_range(1) == 1);
            run_xact(($urandom_range(1) == 1), $urandom & 32'hFFFF_FF80, $urandom, 1'b0);
        end
        spur_en = 1'b0;

        // Reset while waiting for fill word 10.
        busy_pct = 0;
        min_lat  = 3;
        max_lat  = 4;
        salt     = $urandom;
        clear_queues();
        @(negedge clk); #2;
        core_req            = 1'b1;
        line_miss           = 1'b1;
        line_dirty          = 1'b0;
        core_addr           = 32'h0000_5040;
        line_memory_section = '0;
        @(negedge clk); #2;
        core_req  = 1'b0;
        line_miss = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 2000 && !seen; n++) begin
            @(negedge clk); #2;
            seen = (rd_q.size() == 11);
        end
        chk("rst_reach_word10", 64'(seen), 64'd1);
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        check_quiet("rst_async");
        chk("rst_fill_before", 64'(fill_q.size()), 64'd10);
        repeat (2) @(negedge clk);
        #2;
        check_quiet("rst_hold");
        reset_n = 1'b1;
        repeat (12) @(negedge clk);
        #2;
        chk("rst_after_busy", 64'(busy), 64'd0);
        chk("rst_after_fill", 64'(fill_q.size()), 64'd10);
        chk("rst_after_rd", 64'(rd_q.size()), 64'd11);
        chk("rst_after_wr", 64'(wr_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
